compressor_n2_pipe: RTL and testbench

COMPRESSOR_N2_PIPE -- requirements
Module: compressor_n2_pipe

---
 rtl/compressor_n2_pipe_pkg.sv | 20 ++
 rtl/compressor_n2_pipe_grp8.sv | 41 ++++
 rtl/compressor_n2_pipe.sv | 150 +++++++++++++++
 tb/tb_compressor_n2_pipe.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compressor_n2_pipe_pkg.sv
// Shared definitions for the two-stage popcount compressor: mode encodings,
// group width and the output count-width helper.
package cmp_pkg;

  // Per-beat compression mode; encoding 3 behaves like exact
  typedef enum logic [1:0] {
    CMP_EXACT     = 2'd0,
    CMP_APPROX_A  = 2'd1,
    CMP_APPROX_B  = 2'd2,
    CMP_EXACT_ALT = 2'd3
  } cmp_mode_e;

  localparam int GRP_W = 8;

  // Bits needed to hold a count from 0 up to and including 'bits'
  function automatic int cnt_width(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/compressor_n2_pipe_grp8.sv
// Combinational 8-bit group counter. Produces the exact popcount of the
// group and the approximate count selected by the mode (approx-B when the
// mode asks for it, approx-A otherwise).
module compressor_grp8
  import cmp_pkg::*;
(
  input  logic [GRP_W-1:0] grp,
  input  logic [1:0]       mode,
  output logic [3:0]       exact_cnt,
  output logic [3:0]       approx_cnt
);

  logic [3:0] hi6_cnt;
  logic [3:0] hi4_cnt;
  logic [3:0] approx_a;
  logic [3:0] approx_b;
  logic       low_or;
  logic       mid_or;

  // Full popcount plus the partial popcounts and OR-collapsed low pairs the approximations use
  always_comb begin
    exact_cnt = '0;
    hi6_cnt   = '0;
    hi4_cnt   = '0;
    for (int i = 0; i < GRP_W; i++) begin
      exact_cnt = exact_cnt + {3'b000, grp[i]};
    end
    for (int i = 2; i < GRP_W; i++) begin
      hi6_cnt = hi6_cnt + {3'b000, grp[i]};
    end
    for (int i = 4; i < GRP_W; i++) begin
      hi4_cnt = hi4_cnt + {3'b000, grp[i]};
    end
    low_or     = grp[1] | grp[0];
    mid_or     = grp[3] | grp[2];
    approx_a   = hi6_cnt + {3'b000, low_or};
    approx_b   = hi4_cnt + {2'b00, mid_or, 1'b0} + {3'b000, low_or};
    approx_cnt = (mode == CMP_APPROX_B) ? approx_b : approx_a;
  end

endmodule

// File: rtl/compressor_n2_pipe.sv
// Two-stage pipelined weighted bit counter with valid/ready handshakes.
// Stage 1 holds per-group exact and approximate counts with the beat's mode;
// stage 2 sums the counts the mode selects into out_cnt.
// Optional feature macro CMP_ERR_STAT_EN: carries the exact sum alongside and
// accumulates |exact - out_cnt| and delivered beats into saturating counters.
module compressor_n2_pipe
  import cmp_pkg::*;
#(
  parameter  int IN_BITS = 16,
  localparam int OUT_W   = cnt_width(IN_BITS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_BITS-1:0] in_data,
  input  logic [1:0]         in_mode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [OUT_W-1:0]   out_cnt,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               stat_clr,
  output logic [15:0]        err_acc,
  output logic [15:0]        beat_cnt
);

  localparam int NG = IN_BITS / GRP_W;

  logic [3:0] grp_exact  [NG];
  logic [3:0] grp_approx [NG];

  logic       s1_valid;
  cmp_mode_e  s1_mode;
  logic [3:0] s1_exact  [NG];
  logic [3:0] s1_approx [NG];

  logic             in_fire;
  logic             s2_load;
  logic             use_exact;
  logic [OUT_W-1:0] sel_sum;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    compressor_grp8 u_grp (
      .grp        (in_data[k*GRP_W +: GRP_W]),
      .mode       (in_mode),
      .exact_cnt  (grp_exact[k]),
      .approx_cnt (grp_approx[k])
    );
  end

  assign s2_load  = !out_valid | out_ready;
  assign in_ready = !s1_valid | s2_load;
  assign in_fire  = in_valid & in_ready;

  // Stage 1 captures group counts and mode on an input transfer, empties when stage 2 takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= CMP_EXACT;
      for (int k = 0; k < NG; k++) begin
        s1_exact[k]  <= '0;
        s1_approx[k] <= '0;
      end
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_mode  <= cmp_mode_e'(in_mode);
      for (int k = 0; k < NG; k++) begin
        s1_exact[k]  <= grp_exact[k];
        s1_approx[k] <= grp_approx[k];
      end
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Sum the per-group counts chosen by the beat's own mode
  always_comb begin
    sel_sum   = '0;
    use_exact = (s1_mode != CMP_APPROX_A) && (s1_mode != CMP_APPROX_B);
    for (int k = 0; k < NG; k++) begin
      sel_sum = sel_sum + OUT_W'(use_exact ? s1_exact[k] : s1_approx[k]);
    end
  end

  // Stage 2 output register; holds under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_cnt   <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_cnt <= sel_sum;
      end
    end
  end

`ifdef CMP_ERR_STAT_EN
  logic [OUT_W-1:0] exact_sum;
  logic [OUT_W-1:0] s2_exact;
  logic [OUT_W-1:0] abs_err;
  logic [16:0]      err_sum;
  logic             out_fire;

  assign out_fire = out_valid & out_ready;

  // Exact sum computed next to the selected sum so the error can be measured
  always_comb begin
    exact_sum = '0;
    for (int k = 0; k < NG; k++) begin
      exact_sum = exact_sum + OUT_W'(s1_exact[k]);
    end
  end

  // Exact count travels alongside out_cnt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_exact <= '0;
    end else if (s2_load && s1_valid) begin
      s2_exact <= exact_sum;
    end
  end

  // Absolute error of the delivered beat, widened for saturation detection
  always_comb begin
    abs_err = (s2_exact >= out_cnt) ? (s2_exact - out_cnt) : (out_cnt - s2_exact);
    err_sum = {1'b0, err_acc} + 17'(abs_err);
  end

  // Saturating statistics; clear wins over a same-cycle delivery
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_acc  <= '0;
      beat_cnt <= '0;
    end else if (stat_clr) begin
      err_acc  <= '0;
      beat_cnt <= '0;
    end else if (out_fire) begin
      err_acc  <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      beat_cnt <= (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
    end
  end
`else
  logic unused_stat_clr;

  assign unused_stat_clr = stat_clr;
  assign err_acc         = '0;
  assign beat_cnt        = '0;
`endif

endmodule

// File: tb/tb_compressor_n2_pipe.sv
// Self-checking bench for compressor_n2_pipe (IN_BITS=16). Expected counts
// come from a bit-level reference model of the group rules; statistics
// expectations follow the CMP_ERR_STAT_EN macro of the build.
module tb_compressor_n2_pipe;

  localparam int IN_BITS = 16;
  localparam int OUT_W   = 5;

  typedef struct {
    int          cnt;
    logic [15:0] d;
    logic [1:0]  m;
  } beat_t;

  logic             clk;
  logic             rst;
  logic [15:0]      in_data;
  logic [1:0]       in_mode;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_cnt;
  logic             out_valid;
  logic             out_ready;
  logic             stat_clr;
  logic [15:0]      err_acc;
  logic [15:0]      beat_cnt;

  int checks;
  int errors;
  int exp_err;
  int exp_beats;

  compressor_n2_pipe #(.IN_BITS(IN_BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_cnt   (out_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .stat_clr  (stat_clr),
    .err_acc   (err_acc),
    .beat_cnt  (beat_cnt)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference count of one beat straight from the group rules
  function automatic int model_cnt(input logic [15:0] d, input logic [1:0] m);
    int total = 0;
    for (int g = 0; g < 2; g++) begin
      logic [7:0] b;
      int hi6, hi4;
      b = d[8*g +: 8];
      hi6 = 0;
      hi4 = 0;
      for (int i = 2; i < 8; i++) hi6 += int'(b[i]);
      for (int i = 4; i < 8; i++) hi4 += int'(b[i]);
      case (m)
        2'd1:    total += hi6 + int'(b[1] | b[0]);
        2'd2:    total += hi4 + 2 * int'(b[3] | b[2]) + int'(b[1] | b[0]);
        default: total += $countones(b);
      endcase
    end
    return total;
  endfunction

  // Expected statistics update for a delivered beat
  task automatic account(input logic [15:0] d, input logic [1:0] m);
`ifdef CMP_ERR_STAT_EN
    int e;
    e = $countones(d) - model_cnt(d, m);
    if (e < 0) e = -e;
    exp_err   = (exp_err + e > 65535) ? 65535 : exp_err + e;
    exp_beats = (exp_beats + 1 > 65535) ? 65535 : exp_beats + 1;
`else
    exp_err   = 0;
    exp_beats = 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one beat with out_ready high and measure its latency (-1 on timeout)
  task automatic run_beat(input logic [15:0] d, input logic [1:0] m,
                          output logic [OUT_W-1:0] cnt, output int lat, output bit acc);
    in_data   = d;
    in_mode   = m;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    acc = in_ready;
    tick();
    in_valid = 1'b0;
    in_mode  = 2'($urandom);
    in_data  = 16'($urandom);
    lat = 1;
    cnt = '0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      lat = -1;
    end else begin
      cnt = out_cnt;
      account(d, m);
    end
    tick();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'($urandom);
    in_mode   = 2'd0;
    out_ready = 1'b0;
    stat_clr  = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid);
    end
    checks++;
    if (out_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL reset_out_cnt: got %0d expected 0", out_cnt);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready);
    end
    checks++;
    if (err_acc !== 16'd0 || beat_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_stats: got err=%0d beats=%0d expected 0 0", err_acc, beat_cnt);
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    exp_err   = 0;
    exp_beats = 0;
    tick();
  endtask

  task automatic test_exact_full();
    logic [OUT_W-1:0] cnt;
    int lat;
    bit acc;
    run_beat(16'hFFFF, 2'd0, cnt, lat, acc);
    checks++;
    if (!acc) begin
      errors++;
      $display("[TB] FAIL exact_accept: got in_ready=0 expected 1");
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("[TB] FAIL exact_latency: got %0d expected 2", lat);
    end
    checks++;
    if (cnt !== 5'd16) begin
      errors++;
      $display("[TB] FAIL exact_cnt: got %0d expected 16", cnt);
    end
    run_beat(16'hA5C3, 2'd3, cnt, lat, acc);
    checks++;
    if (int'(cnt) != model_cnt(16'hA5C3, 2'd3) || lat != 2) begin
      errors++;
      $display("[TB] FAIL mode3_cnt: got %0d lat %0d expected %0d lat 2", cnt, lat, model_cnt(16'hA5C3, 2'd3));
    end
  endtask

  task automatic test_approx_a();
    logic [OUT_W-1:0] cnt;
    int lat;
    bit acc;
    stat_clr = 1'b1;
    tick();
    stat_clr  = 1'b0;
    exp_err   = 0;
    exp_beats = 0;
    run_beat(16'h0303, 2'd1, cnt, lat, acc);
    checks++;
    if (cnt !== 5'd2 || lat != 2) begin
      errors++;
      $display("[TB] FAIL approx_a_cnt: got %0d lat %0d expected 2 lat 2", cnt, lat);
    end
    checks++;
    if (int'(err_acc) != exp_err || int'(beat_cnt) != exp_beats) begin
      errors++;
      $display("[TB] FAIL approx_a_stats: got err=%0d beats=%0d expected %0d %0d", err_acc, beat_cnt, exp_err, exp_beats);
    end
  endtask

  task automatic test_approx_b();
    logic [OUT_W-1:0] cnt;
    int lat;
    bit acc;
    run_beat(16'h00FF, 2'd2, cnt, lat, acc);
    checks++;
    if (cnt !== 5'd7 || lat != 2) begin
      errors++;
      $display("[TB] FAIL approx_b_cnt: got %0d lat %0d expected 7 lat 2", cnt, lat);
    end
    checks++;
    if (int'(err_acc) != exp_err || int'(beat_cnt) != exp_beats) begin
      errors++;
      $display("[TB] FAIL approx_b_stats: got err=%0d beats=%0d expected %0d %0d", err_acc, beat_cnt, exp_err, exp_beats);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] d [3];
    logic [1:0]  m [3];
    int k;
    int outs [$];
    bit fire_in;
    for (int i = 0; i < 3; i++) begin
      d[i] = 16'($urandom);
      m[i] = 2'($urandom);
    end
    k = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = d[k];
      in_mode  = m[k];
      #1;
      checks++;
      if (in_ready !== ((c < 2) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("[TB] FAIL bp_in_ready c%0d: got %0b expected %0b", c, in_ready, (c < 2));
      end
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || int'(out_cnt) != model_cnt(d[0], m[0])) begin
          errors++;
          $display("[TB] FAIL bp_hold c%0d: got valid=%0b cnt=%0d expected 1 %0d", c, out_valid, out_cnt, model_cnt(d[0], m[0]));
        end
      end
      if (in_ready && k < 2) k++;
      tick();
    end
    checks++;
    if (k != 2) begin
      errors++;
      $display("[TB] FAIL bp_accepted: got %0d expected 2", k);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d[2];
    in_mode   = m[2];
    for (int c = 0; c < 8; c++) begin
      #1;
      fire_in = in_valid && in_ready;
      if (fire_in) k++;
      if (out_valid) outs.push_back(int'(out_cnt));
      tick();
      if (fire_in) in_valid = 1'b0;
    end
    checks++;
    if (k != 3) begin
      errors++;
      $display("[TB] FAIL bp_third_accept: got %0d accepted expected 3", k);
    end
    checks++;
    if (outs.size() != 3) begin
      errors++;
      $display("[TB] FAIL bp_out_count: got %0d expected 3", outs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        account(d[i], m[i]);
        checks++;
        if (outs[i] != model_cnt(d[i], m[i])) begin
          errors++;
          $display("[TB] FAIL bp_order[%0d]: got %0d expected %0d", i, outs[i], model_cnt(d[i], m[i]));
        end
      end
    end
  endtask

  task automatic test_random();
    beat_t q [$];
    beat_t b;
    bit fin, fout, stall;
    int held;
    int budget;
    stall = 1'b0;
    held  = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      in_mode   = 2'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || int'(out_cnt) != held) begin
          errors++;
          $display("[TB] FAIL rand_stable c%0d: got valid=%0b cnt=%0d expected 1 %0d", c, out_valid, out_cnt, held);
        end
      end
      fin  = in_valid && in_ready;
      fout = out_valid && out_ready;
      if (fout) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("[TB] FAIL rand_spurious c%0d: got cnt=%0d expected no output", c, out_cnt);
        end else begin
          b = q.pop_front();
          account(b.d, b.m);
          if (int'(out_cnt) != b.cnt) begin
            errors++;
            $display("[TB] FAIL rand_cnt c%0d: got %0d expected %0d", c, out_cnt, b.cnt);
          end
        end
      end
      stall = out_valid && !out_ready;
      held  = int'(out_cnt);
      if (fin) q.push_back('{model_cnt(in_data, in_mode), in_data, in_mode});
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget = 0;
    while (q.size() != 0 && budget < 20) begin
      #1;
      if (out_valid) begin
        b = q.pop_front();
        account(b.d, b.m);
        checks++;
        if (int'(out_cnt) != b.cnt) begin
          errors++;
          $display("[TB] FAIL rand_drain: got %0d expected %0d", out_cnt, b.cnt);
        end
      end
      tick();
      budget++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rand_timeout: got %0d beats outstanding expected 0", q.size());
    end
    checks++;
    if (int'(err_acc) != exp_err || int'(beat_cnt) != exp_beats) begin
      errors++;
      $display("[TB] FAIL rand_stats: got err=%0d beats=%0d expected %0d %0d", err_acc, beat_cnt, exp_err, exp_beats);
    end
  endtask

  task automatic test_reset_inflight();
    bit stale;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = 16'($urandom);
      in_mode = 2'($urandom);
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_flight: got valid=%0b ready=%0b expected 0 1", out_valid, in_ready);
    end
    tick();
    rst       = 1'b0;
    exp_err   = 0;
    exp_beats = 0;
    out_ready = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) stale = 1'b1;
      tick();
    end
    checks++;
    if (stale) begin
      errors++;
      $display("[TB] FAIL rst_stale: got output after reset expected none");
    end
    checks++;
    if (err_acc !== 16'd0 || beat_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL rst_stats: got err=%0d beats=%0d expected 0 0", err_acc, beat_cnt);
    end
  endtask

  task automatic test_saturation();
    localparam int N = 32770;
    logic [OUT_W-1:0] cnt;
    int lat;
    bit acc;
    stat_clr = 1'b1;
    tick();
    stat_clr  = 1'b0;
    exp_err   = 0;
    exp_beats = 0;
    in_data   = 16'h0303;
    in_mode   = 2'd1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      account(16'h0303, 2'd1);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (int'(err_acc) != exp_err || int'(beat_cnt) != exp_beats) begin
      errors++;
      $display("[TB] FAIL sat_stream: got err=%0d beats=%0d expected %0d %0d", err_acc, beat_cnt, exp_err, exp_beats);
    end
    run_beat(16'h0303, 2'd1, cnt, lat, acc);
    checks++;
    if (int'(err_acc) != exp_err) begin
      errors++;
      $display("[TB] FAIL sat_hold: got err=%0d expected %0d", err_acc, exp_err);
    end
    in_data  = 16'h0303;
    in_mode  = 2'd1;
    in_valid = 1'b1;
    tick();
    tick();
    stat_clr = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr_setup: got valid=%0b ready=%0b expected 1 1", out_valid, in_ready);
    end
    tick();
    stat_clr  = 1'b0;
    in_valid  = 1'b0;
    exp_err   = 0;
    exp_beats = 0;
    checks++;
    if (err_acc !== 16'd0 || beat_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL clr_priority: got err=%0d beats=%0d expected 0 0", err_acc, beat_cnt);
    end
    repeat (4) tick();
    account(16'h0303, 2'd1);
    account(16'h0303, 2'd1);
    checks++;
    if (int'(err_acc) != exp_err || int'(beat_cnt) != exp_beats) begin
      errors++;
      $display("[TB] FAIL clr_after: got err=%0d beats=%0d expected %0d %0d", err_acc, beat_cnt, exp_err, exp_beats);
    end
  endtask

  // Test sequence
  initial begin
    checks    = 0;
    errors    = 0;
    exp_err   = 0;
    exp_beats = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    stat_clr  = 1'b0;
    test_reset();
    test_exact_full();
    test_approx_a();
    test_approx_b();
    test_backpressure();
    test_random();
    test_reset_inflight();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
